// File: rtl/watch_disp_ctrl.sv
// Mode/set controller for the 6-digit watch display: selects time, alarm or
// stopwatch for display and runs the key-driven time/alarm edit sequence.
module watch_disp_ctrl #(
    parameter int EDIT_TIMEOUT = 20,
    parameter int TO_W         = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       blink_tick,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_inc,
    input  logic [7:0] Time_Hour,
    input  logic [7:0] Time_Minute,
    input  logic [7:0] Time_Second,
    input  logic [7:0] Alarm_Hour,
    input  logic [7:0] Alarm_Minute,
    input  logic [7:0] Sw_Minute,
    input  logic [7:0] Sw_Second,
    input  logic [7:0] Sw_Centi,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic [5:0] Blank,
    output logic [1:0] Mode,
    output logic       Set_Load,
    output logic       Set_Target,
    output logic [7:0] Set_Hour,
    output logic [7:0] Set_Minute,
    output logic [7:0] Set_Second
);

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        SHOW_ALARM = 3'd1,
        SHOW_SW    = 3'd2,
        EDIT_HOUR  = 3'd3,
        EDIT_MIN   = 3'd4,
        EDIT_SEC   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            origin_q, origin_d;
    logic [7:0]      eh_q, eh_d, em_q, em_d, es_q, es_d;
    logic            phase_q, phase_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            load_d;
    logic [7:0]      hour_d, minute_d, second_d;
    logic [5:0]      blank_d;
    logic [1:0]      mode_d;

    // Out-of-range snapshot values also land on 0 at the first increment.
    function automatic logic [7:0] bump(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? 8'd0 : v + 8'd1;
    endfunction

    // Next-state, edit-register and display-mux logic.
    always_comb begin
        state_d  = state_q;
        origin_d = origin_q;
        eh_d     = eh_q;
        em_d     = em_q;
        es_d     = es_q;
        phase_d  = phase_q;
        to_d     = to_q;
        load_d   = 1'b0;
        case (state_q)
            SHOW_TIME, SHOW_ALARM, SHOW_SW: begin
                if (key_mode) begin
                    case (state_q)
                        SHOW_TIME:  state_d = SHOW_ALARM;
                        SHOW_ALARM: state_d = SHOW_SW;
                        default:    state_d = SHOW_TIME;
                    endcase
                end else if (key_sel && (state_q != SHOW_SW)) begin
                    origin_d = (state_q == SHOW_ALARM);
                    eh_d     = (state_q == SHOW_ALARM) ? Alarm_Hour   : Time_Hour;
                    em_d     = (state_q == SHOW_ALARM) ? Alarm_Minute : Time_Minute;
                    es_d     = (state_q == SHOW_ALARM) ? 8'd0         : Time_Second;
                    state_d  = EDIT_HOUR;
                    phase_d  = 1'b0;
                    to_d     = '0;
                end else begin
                    state_d = state_q;
                end
            end
            EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                if (key_mode) begin
                    state_d = origin_q ? SHOW_ALARM : SHOW_TIME;
                    phase_d = 1'b0;
                    to_d    = '0;
                end else if (key_sel) begin
                    phase_d = 1'b0;
                    to_d    = '0;
                    if (state_q == EDIT_HOUR) begin
                        state_d = EDIT_MIN;
                    end else if ((state_q == EDIT_MIN) && !origin_q) begin
                        state_d = EDIT_SEC;
                    end else begin
                        load_d  = 1'b1;
                        state_d = origin_q ? SHOW_ALARM : SHOW_TIME;
                    end
                end else if (key_inc) begin
                    phase_d = 1'b0;
                    to_d    = '0;
                    case (state_q)
                        EDIT_HOUR: eh_d = bump(eh_q, 8'd23);
                        EDIT_MIN:  em_d = bump(em_q, 8'd59);
                        default:   es_d = bump(es_q, 8'd59);
                    endcase
                end else if (blink_tick) begin
                    if (to_q == TO_W'(EDIT_TIMEOUT - 1)) begin
                        state_d = origin_q ? SHOW_ALARM : SHOW_TIME;
                        phase_d = 1'b0;
                        to_d    = '0;
                    end else begin
                        to_d    = to_q + TO_W'(1);
                        phase_d = ~phase_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = SHOW_TIME;
                phase_d = 1'b0;
                to_d    = '0;
            end
        endcase

        // Outputs follow the next state so a key press is visible on the same edge.
        blank_d = 6'b000000;
        case (state_d)
            SHOW_TIME: begin
                hour_d = Time_Hour;  minute_d = Time_Minute;  second_d = Time_Second;
                mode_d = 2'd0;
            end
            SHOW_ALARM: begin
                hour_d = Alarm_Hour; minute_d = Alarm_Minute; second_d = 8'd0;
                mode_d = 2'd1;
            end
            SHOW_SW: begin
                hour_d = Sw_Minute;  minute_d = Sw_Second;    second_d = Sw_Centi;
                mode_d = 2'd2;
            end
            default: begin
                hour_d   = eh_d;
                minute_d = em_d;
                second_d = origin_d ? 8'd0 : es_d;
                mode_d   = {1'b0, origin_d};
                if (phase_d) begin
                    case (state_d)
                        EDIT_HOUR: blank_d = 6'b110000;
                        EDIT_MIN:  blank_d = 6'b001100;
                        default:   blank_d = 6'b000011;
                    endcase
                end else begin
                    blank_d = 6'b000000;
                end
            end
        endcase
    end

    // State, edit registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SHOW_TIME;
            origin_q   <= 1'b0;
            eh_q       <= 8'd0;
            em_q       <= 8'd0;
            es_q       <= 8'd0;
            phase_q    <= 1'b0;
            to_q       <= '0;
            Hour       <= 8'd0;
            Minute     <= 8'd0;
            Second     <= 8'd0;
            Blank      <= 6'd0;
            Mode       <= 2'd0;
            Set_Load   <= 1'b0;
            Set_Target <= 1'b0;
            Set_Hour   <= 8'd0;
            Set_Minute <= 8'd0;
            Set_Second <= 8'd0;
        end else begin
            state_q    <= state_d;
            origin_q   <= origin_d;
            eh_q       <= eh_d;
            em_q       <= em_d;
            es_q       <= es_d;
            phase_q    <= phase_d;
            to_q       <= to_d;
            Hour       <= hour_d;
            Minute     <= minute_d;
            Second     <= second_d;
            Blank      <= blank_d;
            Mode       <= mode_d;
            Set_Load   <= load_d;
            Set_Target <= load_d ? origin_q : 1'b0;
            Set_Hour   <= load_d ? eh_q : 8'd0;
            Set_Minute <= load_d ? em_q : 8'd0;
            Set_Second <= load_d ? es_q : 8'd0;
        end
    end

endmodule

// File: doc/watch_disp_ctrl.md
Name: watch_disp_ctrl

Overview:
- Mode/set controller in front of the 6-digit multiplexed display driver.
- Selects which hour/minute/second triple is shown: time of day, alarm, or stopwatch.
- Runs the key-driven edit sequence for time and alarm, blanking the field being edited at the blink rate.
- Emits a one-cycle load strobe and value for the timekeeper or alarm register when an edit is committed.

Parameters:
- EDIT_TIMEOUT, 20, blink_tick pulses with no key press before an edit is aborted (20 = 10 s at 2 Hz).
- TO_W, 5, width of the timeout counter; must hold EDIT_TIMEOUT.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- blink_tick  input  1  one-cycle pulse at 2 Hz.
- key_mode  input  1  debounced one-cycle pulse.
- key_sel  input  1  debounced one-cycle pulse.
- key_inc  input  1  debounced one-cycle pulse.
- Time_Hour, Time_Minute, Time_Second  input  8 each  time of day, binary.
- Alarm_Hour, Alarm_Minute  input  8 each  alarm setting, binary.
- Sw_Minute, Sw_Second, Sw_Centi  input  8 each  stopwatch value, binary.
- Hour, Minute, Second  output  8 each  triple sent to the display driver (registered).
- Blank  output  6  per-digit blank, 1 = digit off. Bit 0 = second ones, 1 = second tens, 2 = minute ones, 3 = minute tens, 4 = hour ones, 5 = hour tens.
- Mode  output  2  0 = time, 1 = alarm, 2 = stopwatch.
- Set_Load  output  1  one-cycle commit strobe.
- Set_Target  output  1  0 = time, 1 = alarm; valid while Set_Load = 1.
- Set_Hour, Set_Minute, Set_Second  output  8 each  committed value; valid while Set_Load = 1.

Behaviour:
- Reset (async, rst_n = 0):
  - State SHOW_TIME; Mode = 0.
  - Hour, Minute, Second, Blank, Set_* all 0.
  - Edit registers, blink phase and timeout counter all 0.
- States: SHOW_TIME, SHOW_ALARM, SHOW_SW, EDIT_HOUR, EDIT_MIN, EDIT_SEC. An origin flag records whether the edit is of time or alarm.
- Key priority when keys coincide in one cycle: key_mode > key_sel > key_inc. Only the highest-priority key acts.
- Show states:
  - key_mode cycles SHOW_TIME -> SHOW_ALARM -> SHOW_SW -> SHOW_TIME.
  - key_inc is ignored.
  - key_sel in SHOW_TIME: snapshot Time_* into the edit registers, origin = time, go to EDIT_HOUR.
  - key_sel in SHOW_ALARM: snapshot Alarm_Hour and Alarm_Minute, edit second = 0, origin = alarm, go to EDIT_HOUR.
  - key_sel in SHOW_SW is ignored.
- Display mux (registered, 1-cycle latency from source to output):
  - SHOW_TIME: Time_*.
  - SHOW_ALARM: Alarm_Hour, Alarm_Minute, Second = 0.
  - SHOW_SW: Hour = Sw_Minute, Minute = Sw_Second, Second = Sw_Centi.
  - EDIT_*: the edit registers. Second = 0 when origin = alarm.
- Mode output: 0 in SHOW_TIME, 1 in SHOW_ALARM, 2 in SHOW_SW. In EDIT_* it equals the origin.
- Edit states:
  - key_inc increments the current field: hour wraps 23 -> 0, minute and second wrap 59 -> 0.
  - A snapshot value already out of range (hour > 23, min/sec > 59) goes to 0 on the first key_inc.
  - key_sel: EDIT_HOUR -> EDIT_MIN. EDIT_MIN -> EDIT_SEC when origin = time; EDIT_MIN commits when origin = alarm. EDIT_SEC commits.
  - Commit: Set_Load = 1 for exactly one cycle with Set_Hour/Minute/Second = edit registers and Set_Target = origin; return to the origin show state in the same cycle.
  - key_mode: abort. No Set_Load; return to the origin show state.
- Timeout:
  - The counter clears on entry to edit and on every key press.
  - It increments on each blink_tick while in EDIT_*.
  - When it reaches EDIT_TIMEOUT, abort exactly as key_mode does.
- Blink:
  - Phase toggles on each blink_tick; it is forced to 0 on entry to edit and on any key, so the edited field is visible immediately after a press.
  - While phase = 1, the two Blank bits of the current field are 1. All other Blank bits are 0.
  - Blank is all 0 in show states.
- Set_Load is never asserted outside a commit.
- Reset asserted mid-edit discards the edit; no load is issued.

Test Plan:
- Reset, then three key_mode pulses: Mode sequence 0 -> 1 -> 2 -> 0. With Sw = 3/7/42 in SHOW_SW, Hour/Minute/Second = 3/7/42 one cycle later.
- Time = 23:59:30, in SHOW_TIME: key_sel, key_inc x1 (hour -> 0), key_sel, key_inc x2 (minute 59 -> 0 -> 1), key_sel, key_inc, key_sel. Expect a single Set_Load with Set_Target = 0 and Set_* = 0/1/31; state returns to SHOW_TIME.
- Alarm = 6:30: Mode = 1, key_sel, key_inc, key_sel, key_sel. Expect Set_Load after the second key_sel (EDIT_SEC skipped) with Set_Target = 1 and values 7/30/0.
- In EDIT_MIN: key_mode and key_inc in the same cycle -> abort, no Set_Load, edit value unchanged on re-entry snapshot. Separately, 20 blink_ticks with no key -> abort; 19 blink_ticks then a key_inc -> still editing.
- Blink: in EDIT_HOUR, Blank alternates 6'b110000 / 6'b000000 on each blink_tick. key_inc forces 6'b000000. In show states Blank = 0.
- Reset mid-edit (rst_n = 0 asynchronously, between clock edges): all outputs 0 immediately, state SHOW_TIME, Set_Load never pulses.
